// File: rtl/burst_line_adaptor_if.sv
// Bus bundle between the LLC, burst_line_adaptor and physical memory.
// slave is the adaptor's view; master is the LLC/memory environment's view.
interface burst_line_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [31:0]            address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/burst_line_adaptor.sv
// Converts one LINE_WIDTH-bit line read/write into BEATS memory beats of BURST_WIDTH bits.
// Optional critical-word-first wrap ordering is enabled by defining CWF_WRAP_EN.
module burst_line_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
) (
  input logic clk,
  input logic rst,
  burst_line_adaptor_if.slave bus
);

  localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam int SUB_BITS = $clog2(BURST_WIDTH / 8);
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef CWF_WRAP_EN
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << SUB_BITS) - 32'd1);
`else
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFF_BITS) - 32'd1);
`endif

  generate
    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || (LINE_WIDTH % BURST_WIDTH) != 0) begin : g_bad_params
      $error("burst_line_adaptor: LINE_WIDTH/BURST_WIDTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] start;
  logic [CNT_W-1:0] idx;
  logic             last_beat;

  logic [BEATS-1:0][BURST_WIDTH-1:0] line_buf;
  logic [BEATS-1:0][BURST_WIDTH-1:0] merged;

  // The counter wraps in CNT_W bits, which gives the modulo-BEATS beat index for free.
  assign idx       = start + count;
  assign last_beat = bus.resp_i && (count == CNT_W'(BEATS - 1));

  // Line buffer with the incoming read beat already placed, so line_o can be loaded on the last beat.
  always_comb begin
    merged      = line_buf;
    merged[idx] = bus.burst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.write_i) begin
          next_state = WRITE;
        end else if (bus.read_i) begin
          next_state = READ;
        end
      end
      READ, WRITE: begin
        if (last_beat) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.read_o  = 1'b0;
    bus.write_o = 1'b0;
    bus.resp_o  = 1'b0;
    bus.burst_o = '0;
    case (state)
      READ:  bus.read_o = 1'b1;
      WRITE: begin
        bus.write_o = 1'b1;
        bus.burst_o = line_buf[idx];
      end
      DONE:    bus.resp_o = 1'b1;
      default: ;
    endcase
  end

`ifdef CWF_WRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      start <= '0;
    end else if (state == IDLE && (bus.write_i || bus.read_i)) begin
      start <= bus.address_i[OFF_BITS-1:SUB_BITS];
    end
  end
`else
  assign start = '0;
`endif

  // Request capture, beat counting and read-beat assembly; a reset abandons any partial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      bus.line_o    <= '0;
      bus.address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            count         <= '0;
            bus.address_o <= bus.address_i & ADDR_MASK;
            if (bus.write_i) begin
              line_buf <= bus.line_i;
            end
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_buf <= merged;
            count    <= count + 1'b1;
            if (last_beat) begin
              bus.line_o <= merged;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Scoreboard bench for burst_line_adaptor: default 256/64 instance plus a 512/128 instance.
// Expectations follow CWF_WRAP_EN when it is defined for the build.
module tb_burst_line_adaptor;

  localparam int LW  = 256;
  localparam int BW  = 64;
  localparam int LW2 = 512;
  localparam int BW2 = 128;

`ifdef CWF_WRAP_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   monEn = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   beats2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_line_adaptor_if #(.LINE_WIDTH(LW),  .BURST_WIDTH(BW))  bus  ();
  burst_line_adaptor_if #(.LINE_WIDTH(LW2), .BURST_WIDTH(BW2)) bus2 ();

  burst_line_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  burst_line_adaptor #(.LINE_WIDTH(LW2), .BURST_WIDTH(BW2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [BW-1:0] data;
  } beat_t;

  typedef struct {
    int           cyc;
    logic [511:0] line;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  done_t done2_q[$];
  beat_t b;
  done_t d;
  done_t d2;
  logic [LW-1:0] lastLine = '0;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One line transfer on the default instance; pat[k] is resp_i in transfer cycle k+1.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [LW-1:0] line, input logic [15:0] pat,
                               input int len, input int rstAt);
    logic [31:0] expAddr;
    int start;
    int acks;
    int idx;
    int cyc0;
    expAddr = CWF ? (addr & ~32'h7) : (addr & ~32'h1F);
    start   = CWF ? int'(addr[4:3]) : 0;
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = wr ? line : ~line;
    @(posedge clk); #1;
    cyc0 = cyc;
    bus.address_i = 32'hFFFF_FFFF;
    bus.line_i    = '1;
    acks = 0;
    for (int k = 0; k < len; k++) begin
      if (k == rstAt) rst = 1'b1;
      idx = (start + acks) % 4;
      bus.resp_i  = pat[k];
      bus.burst_i = pat[k] ? line[idx*BW +: BW] : 64'hBAD0_BAD0_BAD0_BAD0;
      beat_q.push_back('{rd: !wr, wr: wr, addr: expAddr, data: wr ? line[idx*BW +: BW] : '0});
      if (pat[k]) acks++;
      @(posedge clk); #1;
    end
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    if (rstAt >= 0) begin
      rst = 1'b0;
      lastLine = '0;
      @(negedge clk);
      checkOutput("rst_read_o",    bus.read_o,    1'b0);
      checkOutput("rst_write_o",   bus.write_o,   1'b0);
      checkOutput("rst_resp_o",    bus.resp_o,    1'b0);
      checkOutput("rst_line_o",    bus.line_o,    '0);
      checkOutput("rst_address_o", bus.address_o, '0);
      checkOutput("rst_burst_o",   bus.burst_o,   '0);
      @(posedge clk); #1;
    end else begin
      done_q.push_back('{cyc: cyc0 + len, line: wr ? lastLine : line});
      if (!wr) lastLine = line;
      @(posedge clk); #1;
    end
  endtask

  // Memory-side and LLC-side monitor for the default instance.
  always @(negedge clk) begin
    if (monEn) begin
      if (bus.read_o || bus.write_o) begin
        if (beat_q.size() == 0) begin
          checkOutput("unexpected_request", {bus.read_o, bus.write_o}, 2'b00);
        end else begin
          b = beat_q.pop_front();
          checkOutput("rd_wr",     {bus.read_o, bus.write_o}, {b.rd, b.wr});
          checkOutput("address_o", bus.address_o, b.addr);
          checkOutput("burst_o",   bus.burst_o,   b.data);
        end
      end
      if (bus.resp_o) begin
        if (done_q.size() == 0) begin
          checkOutput("unexpected_resp", bus.resp_o, 1'b0);
        end else begin
          d = done_q.pop_front();
          checkOutput("resp_cycle", cyc, d.cyc);
          checkOutput("line_o",     bus.line_o, d.line);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (monEn) begin
      if (bus2.read_o && bus2.resp_i) beats2++;
      if (bus2.resp_o) begin
        if (done2_q.size() == 0) begin
          checkOutput("unexpected_resp2", bus2.resp_o, 1'b0);
        end else begin
          d2 = done2_q.pop_front();
          checkOutput("resp2_cycle",  cyc, d2.cyc);
          checkOutput("line2_o",      bus2.line_o, d2.line);
          checkOutput("beats2",       beats2, 4);
          checkOutput("address2_o",   bus2.address_o, 32'h0000_2000);
        end
        beats2 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [LW-1:0]  lineA;
    logic [LW-1:0]  lineW;
    logic [LW-1:0]  lineS;
    logic [LW-1:0]  lineC;
    logic [LW2-1:0] line2;
    int c0;
    lineA = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    lineW = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
             64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    lineS = {64'h5A5A_0000_0000_0003, 64'h5A5A_0000_0000_0002,
             64'h5A5A_0000_0000_0001, 64'h5A5A_0000_0000_0000};
    lineC = {64'hC0DE_0003_C0DE_0003, 64'hC0DE_0002_C0DE_0002,
             64'hC0DE_0001_C0DE_0001, 64'hC0DE_0000_C0DE_0000};
    line2 = {128'hAAAA_0003_AAAA_0003_AAAA_0003_AAAA_0003, 128'hAAAA_0002_AAAA_0002_AAAA_0002_AAAA_0002,
             128'hAAAA_0001_AAAA_0001_AAAA_0001_AAAA_0001, 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0000};

    bus.line_i = '0;  bus.address_i = '0;  bus.read_i = 1'b0;  bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    bus2.line_i = '0; bus2.address_i = '0; bus2.read_i = 1'b0; bus2.write_i = 1'b0;
    bus2.burst_i = '0; bus2.resp_i = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("init_read_o",    bus.read_o,    1'b0);
    checkOutput("init_write_o",   bus.write_o,   1'b0);
    checkOutput("init_resp_o",    bus.resp_o,    1'b0);
    checkOutput("init_line_o",    bus.line_o,    '0);
    checkOutput("init_address_o", bus.address_o, '0);
    checkOutput("init_burst_o",   bus.burst_o,   '0);
    @(posedge clk); #1;
    rst = 1'b0;
    monEn = 1'b1;

    $display("[TB] read, no stalls");
    applyStimulus(1'b1, 1'b0, 32'h0000_1024, lineA, 16'b1111, 4, -1);
    $display("[TB] write with stalls");
    applyStimulus(1'b0, 1'b1, 32'h0000_2008, lineW, 16'b1011001, 7, -1);
    $display("[TB] simultaneous read and write");
    applyStimulus(1'b1, 1'b1, 32'h0000_3000, lineS, 16'b11101, 5, -1);
    $display("[TB] reset mid-read");
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, lineC, 16'b011, 3, 2);
    $display("[TB] read at 0x1010 with stalls");
    applyStimulus(1'b1, 1'b0, 32'h0000_1010, lineC, 16'b110101, 6, -1);
    $display("[TB] write after read holds line_o");
    applyStimulus(1'b0, 1'b1, 32'h0000_5030, lineA, 16'b1111, 4, -1);

    $display("[TB] 512/128 instance read");
    bus2.read_i = 1'b1;
    bus2.address_i = 32'h0000_2000;
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      bus2.resp_i  = 1'b1;
      bus2.burst_i = line2[k*BW2 +: BW2];
      @(posedge clk); #1;
    end
    bus2.resp_i = 1'b0;
    bus2.read_i = 1'b0;
    done2_q.push_back('{cyc: c0 + 4, line: line2});
    repeat (4) @(posedge clk);
    #1;

    checkOutput("beat_q_empty",  beat_q.size(),  0);
    checkOutput("done_q_empty",  done_q.size(),  0);
    checkOutput("done2_q_empty", done2_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
